des_key_sched: RTL and testbench

- Iterative DES key-schedule generator. Emits the 16 48-bit round subkeys, one per accepted handshake.
- Supports the encrypt order (K1..K16, left rotations) and the decrypt order (K16..K1, right rotations).
- Sits beside the round datapath, between the initial and final bit permutations.
- Replaces a 16-entry subkey table, so only one subkey is held at any time.

---
 rtl/des_key_sched.sv | 134 +++++++++++++
 tb/tb_des_key_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// Iterative DES key schedule. C/D halves are loaded from PC-1 and rotated once per
// accepted subkey. Encrypt order rotates left (K1..K16); decrypt order rotates right (K16..K1).
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [1:48] subkey,
  output logic [3:0]  round,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start; C,D hold the last schedule's values
  // RUN   | subkey for the current round is presented; advance on handshake
  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [1:28] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [1:56] pc1_key;
  logic [1:56] cd;
  logic        shift_two;

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  // S(n) is 1 for n in {1,2,9,16}, otherwise 2
  function automatic logic single_shift(input logic [4:0] n);
    return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
  endfunction

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[i+1] = key[PC1[i]];
  end

  assign cd = {c_q, d_q};
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[i+1] = cd[PC2[i]];
  end

  assign shift_two = mode_q ? !single_shift(5'd16 - {1'b0, round_q})
                            : !single_shift({1'b0, round_q} + 5'd2);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d     = decrypt ? pc1_key[1:28]  : rotl(pc1_key[1:28], 1'b0);
          d_d     = decrypt ? pc1_key[29:56] : rotl(pc1_key[29:56], 1'b0);
          mode_d  = decrypt;
          round_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            c_d     = mode_q ? rotr(c_q, shift_two) : rotl(c_q, shift_two);
            d_d     = mode_q ? rotr(d_q, shift_two) : rotl(d_q, shift_two);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign subkey_valid = (state_q == RUN);
  assign round        = round_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic 133457799BBCDFF1 known-answer subkeys.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] key_in = '0;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready = 1'b1;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  // same key with the low (parity) bit of every byte inverted
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;

  logic [47:0] ek [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key_in),
    .busy         (busy),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round        (round),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_valid"},  64'(subkey_valid), 64'd0);
    chk({tag, "_subkey"}, 64'(subkey), 64'd0);
    chk({tag, "_round"},  64'(round), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
  endtask

  // Called at a negedge; runs one full schedule and ends at the negedge showing done.
  task automatic run_sched(input string tag, input logic dec, input logic [63:0] k,
                           input int stall_at, input int junk_at, input bit b2b);
    logic [47:0] exp;
    int busy_cnt;
    busy_cnt = 0;
    start   = 1'b1;
    key_in  = k;
    decrypt = dec;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      exp = dec ? ek[15-r] : ek[r];
      chk({tag, "_valid"},  64'(subkey_valid), 64'd1);
      chk({tag, "_round"},  64'(round), 64'(r));
      chk({tag, "_subkey"}, 64'(subkey), 64'(exp));
      chk({tag, "_done_lo"}, 64'(done), 64'd0);
      if (busy) busy_cnt++;
      if (r == junk_at) begin
        start   = 1'b1;
        key_in  = '0;
        decrypt = ~dec;
      end
      if (r == stall_at) begin
        subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk({tag, "_stall_valid"},  64'(subkey_valid), 64'd1);
          chk({tag, "_stall_round"},  64'(round), 64'(r));
          chk({tag, "_stall_subkey"}, 64'(subkey), 64'(exp));
          if (busy) busy_cnt++;
        end
        subkey_ready = 1'b1;
      end
      @(negedge clk);
      start   = 1'b0;
      key_in  = k;
      decrypt = dec;
    end
    chk({tag, "_done"},      64'(done), 64'd1);
    chk({tag, "_busy_end"},  64'(busy), 64'd0);
    chk({tag, "_valid_end"}, 64'(subkey_valid), 64'd0);
    chk({tag, "_hold_key"},  64'(subkey), 64'(dec ? ek[0] : ek[15]));
    chk({tag, "_busy_cnt"},  64'(busy_cnt), 64'(stall_at >= 0 ? 21 : 16));
    if (!b2b) begin
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    subkey_ready = 1'b1;
    #1;
    chk_idle_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_zero("post_reset");

    run_sched("enc", 1'b0, KEY_A, -1, -1, 1'b0);
    run_sched("dec", 1'b0 ^ 1'b1, KEY_A, -1, -1, 1'b0);
    run_sched("stall", 1'b0, KEY_A, 3, -1, 1'b0);
    run_sched("junk", 1'b0, KEY_A, -1, 7, 1'b0);

    // abort at round 9 with an asynchronous reset between clock edges
    start   = 1'b1;
    key_in  = KEY_A;
    decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 9; r++) @(negedge clk);
    chk("abort_round9", 64'(round), 64'd9);
    chk("abort_subkey9", 64'(subkey), 64'(ek[9]));
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero("abort_async");
    @(negedge clk);
    chk_idle_zero("abort_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    run_sched("restart", 1'b0, KEY_A, -1, -1, 1'b0);

    // back-to-back: second start lands in the done cycle; parity-flipped key
    run_sched("b2b_a", 1'b0, KEY_A, -1, -1, 1'b1);
    run_sched("b2b_p", 1'b0, KEY_P, -1, -1, 1'b1);
    run_sched("b2b_pd", 1'b1, KEY_P, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
